nvram_upload_ctrl: RTL and testbench
====================================

NVRAM_UPLOAD_CTRL -- requirements
Module: nvram_upload_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: NVRAM address width; NVRAM size 2^ADDR_W bytes.
REQ-002 Parameter NV_INDEX, default 8'd4: ioctl_index value selecting NVRAM transfers.
REQ-003 Parameter RAM_LAT, default 1: NVRAM read latency in clk_sys cycles, 1..3.
REQ-004 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_upload  in  1  HPS upload session active.
REQ-007 ioctl_index  in  8  transfer target index.
REQ-008 ioctl_addr  in  25  byte address of current upload read, stable from ioctl_rd until ioctl_wait falls.
REQ-009 ioctl_rd  in  1  one-cycle read request strobe from HPS.
REQ-010 ioctl_din  out  8  read data returned to HPS.
REQ-011 ioctl_wait  out  1  high while a read is outstanding; HPS holds off while high.
REQ-012 nv_addr  out  ADDR_W  NVRAM read-port address.
REQ-013 nv_rd  out  1  NVRAM read-port enable, one cycle per access.
REQ-014 nv_q  in  8  NVRAM read data, valid RAM_LAT cycles after nv_rd.
REQ-015 cpu_nv_busy  in  1  CPU owns the shared NVRAM port this cycle; block SHALL NOT assert nv_rd then.
REQ-016 cpu_nv_wr  in  1  CPU wrote NVRAM this cycle.
REQ-017 nv_dirty  out  1  NVRAM modified since last completed upload.

Function
REQ-018 sel = ioctl_upload && ioctl_index==NV_INDEX; ioctl_rd SHALL be ignored when sel is 0.
REQ-019 FSM states: IDLE, ARB, READ, DONE; reset state IDLE.
REQ-020 IDLE: ioctl_rd && sel && ioctl_addr < 2^ADDR_W -> ARB, ioctl_wait=1 from next cycle.
REQ-021 IDLE: ioctl_rd && sel && ioctl_addr >= 2^ADDR_W -> DONE with ioctl_din=8'h00, no nv_rd, ioctl_wait high exactly one cycle.
REQ-022 ARB: if cpu_nv_busy=0, assert nv_rd with nv_addr=ioctl_addr[ADDR_W-1:0] for one cycle, load latency counter with RAM_LAT, -> READ; else stay ARB (unbounded wait).
REQ-023 READ: decrement counter each cycle; when it reaches zero, capture nv_q into ioctl_din -> DONE.
REQ-024 DONE: ioctl_wait=0 (registered), -> IDLE; ioctl_din held until next capture.
REQ-025 Latency with port free: ioctl_wait falls exactly RAM_LAT+2 cycles after the ioctl_rd cycle; each busy cycle in ARB adds one.
REQ-026 ioctl_rd while state != IDLE SHALL be ignored; outstanding read completes unaffected.
REQ-027 sel falling while in ARB or READ: abort to IDLE next cycle, ioctl_wait=0, ioctl_din unchanged, no further nv_rd.
REQ-028 nv_rd SHALL be high at most one cycle per accepted request; nv_addr SHALL hold last value when nv_rd low.
REQ-029 cpu_nv_wr SHALL set nv_dirty and a wr_during flag the next cycle.
REQ-030 wr_during SHALL clear on rising edge of sel.
REQ-031 On falling edge of sel, if at least one in-range read completed this session and wr_during=0, nv_dirty SHALL clear.
REQ-032 cpu_nv_wr in the same cycle as sel falling: nv_dirty SHALL remain 1.

Reset
REQ-033 reset SHALL force: state IDLE, ioctl_wait=0, ioctl_din=8'h00, nv_rd=0, nv_addr=0, nv_dirty=0, wr_during=0, completed-read flag=0.
REQ-034 reset mid-read SHALL abandon the access; no late capture of nv_q after reset deasserts.

Verification
REQ-035 RAM_LAT=1, NVRAM[0x005]=8'hA5, sel=1, ioctl_rd with addr 0x005, cpu_nv_busy=0 -> one nv_rd at addr 0x005, ioctl_din=8'hA5, ioctl_wait falls 3 cycles after rd.
REQ-036 Same read with cpu_nv_busy high 4 cycles -> nv_rd only after busy drops; ioctl_wait falls 7 cycles after rd.
REQ-037 ioctl_rd with addr 0x400 (ADDR_W=10) -> no nv_rd, ioctl_din=8'h00, ioctl_wait high one cycle.
REQ-038 cpu_nv_wr pulse, then full upload of 1024 bytes with no CPU writes, sel drops -> nv_dirty 1 then 0; repeat with cpu_nv_wr mid-upload -> nv_dirty stays 1.
REQ-039 ioctl_upload dropped in READ -> ioctl_wait 0 next cycle, state IDLE; second ioctl_rd during ARB -> ignored, single nv_rd.
REQ-040 reset asserted in READ -> all outputs at reset values next cycle, ioctl_din not updated afterward.

Source files
------------

// File: rtl/nvram_upload_ctrl.sv
// ----------------------------------------------------------------------------
// nvram_upload_ctrl
//
// Serves HPS upload reads of the NVRAM image. When an upload session targets
// NV_INDEX, each ioctl_rd strobe is turned into one access on the NVRAM read
// port. The port is shared with the CPU, which has priority. The returned byte
// goes back on ioctl_din, and ioctl_wait stalls the HPS while the access is in
// flight. The block also tracks whether the CPU has modified NVRAM since the
// last completed upload (nv_dirty).
//
// Ports
//   clk_sys      in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   ioctl_upload in   HPS upload session active
//   ioctl_index  in   transfer target index
//   ioctl_addr   in   byte address of the current upload read
//   ioctl_rd     in   one-cycle read request strobe
//   ioctl_din    out  read data returned to the HPS (registered)
//   ioctl_wait   out  high while a read is outstanding (registered)
//   nv_addr      out  NVRAM read-port address
//   nv_rd        out  NVRAM read-port enable, one cycle per access
//   nv_q         in   NVRAM read data, valid RAM_LAT cycles after nv_rd
//   cpu_nv_busy  in   CPU owns the NVRAM port this cycle
//   cpu_nv_wr    in   CPU wrote NVRAM this cycle
//   nv_dirty     out  NVRAM modified since the last completed upload
// ----------------------------------------------------------------------------
module nvram_upload_ctrl #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [7:0]  NV_INDEX = 8'd4,
   parameter int unsigned RAM_LAT  = 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic              ioctl_rd,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] nv_addr,
   output logic              nv_rd,
   input  logic [7:0]        nv_q,
   input  logic              cpu_nv_busy,
   input  logic              cpu_nv_wr,
   output logic              nv_dirty
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_READ = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RAM_LAT);

   state_t            state_q, state_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic [7:0]        din_q, din_d;
   logic              wait_q, wait_d;
   logic [ADDR_W-1:0] nv_addr_q, nv_addr_d;
   logic              sel_q;
   logic              dirty_q, dirty_d;
   logic              wr_during_q, wr_during_d;
   logic              rd_done_q, rd_done_d;

   logic sel_s;
   logic sel_rise_s;
   logic sel_fall_s;
   logic in_range_s;
   logic grant_s;
   logic capture_s;

   assign sel_s      = ioctl_upload && (ioctl_index == NV_INDEX);
   assign sel_rise_s = sel_s && !sel_q;
   assign sel_fall_s = !sel_s && sel_q;
   assign in_range_s = ((ioctl_addr >> ADDR_W) == 25'd0);

   // The CPU's busy flag is only known in the cycle it applies to, so the
   // port request is decoded combinationally from the ARB state. It is
   // withheld on a session drop or reset so that no access starts then.
   assign grant_s   = (state_q == ST_ARB) && sel_s && !cpu_nv_busy && !reset;
   assign nv_addr_d = grant_s ? ioctl_addr[ADDR_W-1:0] : nv_addr_q;

   assign nv_rd      = grant_s;
   assign nv_addr    = nv_addr_d;
   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign nv_dirty   = dirty_q;

   // State and data registers with synchronous reset
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lat_cnt_q   <= 2'd0;
         din_q       <= 8'h00;
         wait_q      <= 1'b0;
         nv_addr_q   <= '0;
         sel_q       <= 1'b0;
         dirty_q     <= 1'b0;
         wr_during_q <= 1'b0;
         rd_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         din_q       <= din_d;
         wait_q      <= wait_d;
         nv_addr_q   <= nv_addr_d;
         sel_q       <= sel_s;
         dirty_q     <= dirty_d;
         wr_during_q <= wr_during_d;
         rd_done_q   <= rd_done_d;
      end
   end

   // Read FSM: next state, latency counter, wait and returned data
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      din_d     = din_q;
      wait_d    = wait_q;
      capture_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ioctl_rd && sel_s) begin
               wait_d = 1'b1;
               if (in_range_s) begin
                  state_d = ST_ARB;
               end else begin
                  // Beyond the NVRAM: answer zero without touching the port;
                  // DONE then drops wait after a single stalled cycle.
                  din_d   = 8'h00;
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            if (!sel_s) begin
               state_d = ST_IDLE;
               wait_d  = 1'b0;
            end else if (!cpu_nv_busy) begin
               lat_cnt_d = LAT_INIT;
               state_d   = ST_READ;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_READ: begin
            if (!sel_s) begin
               state_d = ST_IDLE;
               wait_d  = 1'b0;
            end else if (lat_cnt_q == 2'd1) begin
               // The counter reaches zero on this cycle, which is exactly
               // RAM_LAT cycles after the port access: nv_q is valid now.
               lat_cnt_d = 2'd0;
               din_d     = nv_q;
               wait_d    = 1'b0;
               capture_s = 1'b1;
               state_d   = ST_DONE;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         ST_DONE: begin
            wait_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            wait_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Dirty tracking across upload sessions
   always_comb begin
      dirty_d     = dirty_q;
      wr_during_d = wr_during_q;
      rd_done_d   = rd_done_q;
      if (sel_rise_s) begin
         wr_during_d = 1'b0;
         rd_done_d   = 1'b0;
      end else if (sel_fall_s) begin
         // A write in the falling cycle itself is caught by the override
         // below, so the image just uploaded is never considered clean then.
         if (rd_done_q && !wr_during_q) begin
            dirty_d = 1'b0;
         end else begin
            dirty_d = dirty_q;
         end
         rd_done_d = 1'b0;
      end else begin
         rd_done_d = rd_done_q;
      end
      if (capture_s) begin
         rd_done_d = 1'b1;
      end else begin
         wr_during_d = wr_during_d;
      end
      if (cpu_nv_wr) begin
         dirty_d     = 1'b1;
         wr_during_d = 1'b1;
      end else begin
         dirty_d = dirty_d;
      end
   end

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for nvram_upload_ctrl: directed scenarios followed by randomized
// traffic, with a transaction-level reference model compared every cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nvram_upload_ctrl;

   localparam int LAT = 1;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [9:0]  nv_addr;
   logic        nv_rd;
   logic [7:0]  nv_q;
   logic        cpu_nv_busy;
   logic        cpu_nv_wr;
   logic        nv_dirty;

   always #5 clk_sys = ~clk_sys;

   nvram_upload_ctrl #(.ADDR_W(10), .NV_INDEX(8'd4), .RAM_LAT(LAT)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .nv_addr(nv_addr),
      .nv_rd(nv_rd), .nv_q(nv_q), .cpu_nv_busy(cpu_nv_busy),
      .cpu_nv_wr(cpu_nv_wr), .nv_dirty(nv_dirty)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [7:0] mem [0:1023];

   // reference model: one outstanding request described by timestamps
   bit         m_active, m_granted, m_sel_prev, m_wr_sess, m_read_ok;
   logic [24:0] m_addr;
   logic [9:0] m_last_addr;
   int         m_done_cyc, m_idle_from;
   logic       e_wait, e_dirty, exp_nv_rd;
   logic [7:0] e_din;
   logic [9:0] exp_nv_addr;

   // NVRAM responder pipeline
   bit         rv [0:3];
   logic [9:0] ra [0:3];
   logic       rd_seen;
   logic [9:0] rd_a;

   // samples of the last completed cycle
   logic       s_wait, s_dirty, s_nvrd;
   logic [7:0] s_din;
   logic [9:0] s_nvaddr;
   int         nvrd_cnt = 0;
   logic [9:0] last_rd_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit sel_now();
      return ioctl_upload && (ioctl_index == 8'd4);
   endfunction

   task automatic model_comb();
      exp_nv_rd   = !reset && m_active && !m_granted && sel_now() && !cpu_nv_busy;
      exp_nv_addr = exp_nv_rd ? m_addr[9:0] : m_last_addr;
   endtask

   task automatic model_seq();
      bit sel;
      sel = sel_now();
      if (reset) begin
         m_active = 1'b0; m_granted = 1'b0; m_sel_prev = 1'b0;
         m_wr_sess = 1'b0; m_read_ok = 1'b0; m_last_addr = 10'd0;
         m_idle_from = 0; e_wait = 1'b0; e_din = 8'h00; e_dirty = 1'b0;
      end else begin
         if (sel && !m_sel_prev) begin
            m_wr_sess = 1'b0; m_read_ok = 1'b0;
         end
         if (!sel && m_sel_prev) begin
            if (m_read_ok && !m_wr_sess && !cpu_nv_wr) e_dirty = 1'b0;
            m_read_ok = 1'b0;
         end
         if (cpu_nv_wr) begin
            e_dirty = 1'b1; m_wr_sess = 1'b1;
         end
         m_sel_prev = sel;
         if (m_active) begin
            if (!sel) begin
               m_active = 1'b0; e_wait = 1'b0; m_idle_from = cyc + 1;
            end else if (!m_granted) begin
               if (!cpu_nv_busy) begin
                  m_granted = 1'b1; m_done_cyc = cyc + LAT; m_last_addr = m_addr[9:0];
               end
            end else if (cyc == m_done_cyc) begin
               e_din = mem[m_addr[9:0]]; e_wait = 1'b0; m_active = 1'b0;
               m_read_ok = 1'b1; m_idle_from = cyc + 2;
            end
         end else if (cyc >= m_idle_from && ioctl_rd && sel) begin
            e_wait = 1'b1;
            if (ioctl_addr < 25'd1024) begin
               m_active = 1'b1; m_granted = 1'b0; m_addr = ioctl_addr;
            end else begin
               e_din = 8'h00; m_idle_from = cyc + 2;
            end
         end else begin
            e_wait = 1'b0;
         end
      end
      cyc++;
   endtask

   // one clock cycle: inputs are already applied for it
   task automatic tick();
      model_comb();
      @(negedge clk_sys);
      s_wait = ioctl_wait; s_din = ioctl_din; s_dirty = nv_dirty;
      s_nvrd = nv_rd; s_nvaddr = nv_addr;
      rd_seen = nv_rd; rd_a = nv_addr;
      if (nv_rd) begin
         nvrd_cnt++; last_rd_addr = nv_addr;
      end
      @(posedge clk_sys);
      model_seq();
      for (int i = 0; i < 3; i++) begin
         rv[i] = rv[i+1]; ra[i] = ra[i+1];
      end
      rv[3] = 1'b0;
      rv[LAT-1] = rd_seen; ra[LAT-1] = rd_a;
      #1;
      nv_q = rv[0] ? mem[ra[0]] : 8'($urandom);
   endtask

   task automatic do_read(input logic [24:0] addr, input int busy_n, output int lat);
      int n;
      ioctl_addr = addr; ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      lat = 0; n = 0;
      do begin
         cpu_nv_busy = (n < busy_n);
         n++;
         tick();
         lat++;
      end while (s_wait && lat < 40);
      cpu_nv_busy = 1'b0;
   endtask

   // cycle-by-cycle comparison against the reference model
   always @(negedge clk_sys) begin
      if (chk_en) begin
         chk("ioctl_wait", 32'(ioctl_wait), 32'(e_wait));
         chk("ioctl_din", 32'(ioctl_din), 32'(e_din));
         chk("nv_dirty", 32'(nv_dirty), 32'(e_dirty));
         chk("nv_rd", 32'(nv_rd), 32'(exp_nv_rd));
         chk("nv_addr", 32'(nv_addr), 32'(exp_nv_addr));
      end
   end

   initial begin
      int lat;
      int r;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[5] = 8'hA5; mem[7] = 8'h3C; mem[9] = 8'h96;
      for (int i = 0; i < 4; i++) begin
         rv[i] = 1'b0; ra[i] = 10'd0;
      end
      reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd4; ioctl_addr = 25'd0;
      ioctl_rd = 1'b0; nv_q = 8'h00; cpu_nv_busy = 1'b0; cpu_nv_wr = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_wait", 32'(s_wait), 32'd0);
      chk("rst_din", 32'(s_din), 32'h00);
      chk("rst_dirty", 32'(s_dirty), 32'd0);
      chk("rst_nv_rd", 32'(s_nvrd), 32'd0);
      chk("rst_nv_addr", 32'(s_nvaddr), 32'd0);
      reset = 1'b0;
      ioctl_upload = 1'b1;
      tick(); tick();

      // plain read, port free
      nvrd_cnt = 0;
      do_read(25'h005, 0, lat);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_din", 32'(s_din), 32'hA5);
      chk("rd_count", 32'(nvrd_cnt), 32'd1);
      chk("rd_addr", 32'(last_rd_addr), 32'h005);

      // same read with the CPU holding the port for four cycles
      nvrd_cnt = 0;
      do_read(25'h005, 4, lat);
      chk("busy_lat", 32'(lat), 32'd7);
      chk("busy_count", 32'(nvrd_cnt), 32'd1);
      chk("busy_din", 32'(s_din), 32'hA5);

      // first address past the NVRAM
      nvrd_cnt = 0;
      do_read(25'h400, 0, lat);
      chk("oor_lat", 32'(lat), 32'd2);
      chk("oor_count", 32'(nvrd_cnt), 32'd0);
      chk("oor_din", 32'(s_din), 32'h00);

      // CPU write, then a clean full upload clears dirty
      ioctl_upload = 1'b0; tick();
      cpu_nv_wr = 1'b1; tick(); cpu_nv_wr = 1'b0; tick();
      chk("dirty_set", 32'(s_dirty), 32'd1);
      ioctl_upload = 1'b1; tick();
      for (int a = 0; a < 1024; a++) begin
         do_read(25'(a), 0, lat);
         chk("upload_lat", 32'(lat), 32'd3);
      end
      chk("dirty_before_drop", 32'(s_dirty), 32'd1);
      ioctl_upload = 1'b0; tick(); tick();
      chk("dirty_cleared", 32'(s_dirty), 32'd0);

      // upload with a CPU write in the middle keeps dirty
      cpu_nv_wr = 1'b1; tick(); cpu_nv_wr = 1'b0;
      ioctl_upload = 1'b1; tick();
      for (int a = 0; a < 1024; a++) begin
         cpu_nv_wr = (a == 512);
         do_read(25'(a), 0, lat);
      end
      cpu_nv_wr = 1'b0;
      ioctl_upload = 1'b0; tick(); tick();
      chk("dirty_kept", 32'(s_dirty), 32'd1);

      // session dropped while the read is in READ
      ioctl_upload = 1'b1; tick();
      do_read(25'h005, 0, lat);
      nvrd_cnt = 0;
      ioctl_addr = 25'h007; ioctl_rd = 1'b1; tick();
      ioctl_rd = 1'b0; tick();
      ioctl_upload = 1'b0; tick();
      tick();
      chk("abort_wait", 32'(s_wait), 32'd0);
      chk("abort_din", 32'(s_din), 32'hA5);
      chk("abort_count", 32'(nvrd_cnt), 32'd1);
      ioctl_upload = 1'b1; tick();
      do_read(25'h007, 0, lat);
      chk("after_abort_lat", 32'(lat), 32'd3);
      chk("after_abort_din", 32'(s_din), 32'h3C);

      // second strobe during ARB is ignored
      nvrd_cnt = 0;
      ioctl_addr = 25'h009; ioctl_rd = 1'b1; cpu_nv_busy = 1'b1; tick();
      tick();
      ioctl_rd = 1'b0; cpu_nv_busy = 1'b0;
      lat = 1;
      while (s_wait && lat < 40) begin
         tick(); lat++;
      end
      chk("dup_lat", 32'(lat), 32'd4);
      chk("dup_din", 32'(s_din), 32'h96);
      tick(); tick(); tick();
      chk("dup_count", 32'(nvrd_cnt), 32'd1);

      // reset while in READ
      ioctl_addr = 25'h00B; ioctl_rd = 1'b1; cpu_nv_wr = 1'b1; tick();
      ioctl_rd = 1'b0; cpu_nv_wr = 1'b0; tick();
      reset = 1'b1; tick();
      reset = 1'b0; tick();
      chk("rrst_wait", 32'(s_wait), 32'd0);
      chk("rrst_din", 32'(s_din), 32'h00);
      chk("rrst_dirty", 32'(s_dirty), 32'd0);
      chk("rrst_nv_rd", 32'(s_nvrd), 32'd0);
      chk("rrst_nv_addr", 32'(s_nvaddr), 32'd0);
      tick(); tick(); tick();
      chk("rrst_din_later", 32'(s_din), 32'h00);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 499) == 0);
         if (!ioctl_upload) ioctl_upload = ($urandom_range(0, 4) == 0);
         else ioctl_upload = ($urandom_range(0, 79) != 0);
         ioctl_index = ($urandom_range(0, 39) == 0) ? 8'd3 : 8'd4;
         if (!m_active) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) ioctl_addr = 25'd1024;
            else if (r == 1) ioctl_addr = 25'd1023;
            else if (r == 2) ioctl_addr = 25'($urandom_range(1025, 33554431));
            else ioctl_addr = 25'($urandom_range(0, 1023));
         end
         ioctl_rd    = ($urandom_range(0, 3) == 0);
         cpu_nv_busy = ($urandom_range(0, 2) == 0);
         cpu_nv_wr   = ($urandom_range(0, 24) == 0);
         tick();
      end
      reset = 1'b0; ioctl_rd = 1'b0; cpu_nv_busy = 1'b0; cpu_nv_wr = 1'b0;
      tick(); tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
